// File: rtl/alu_li_pkg.sv
// Shared definitions for the latency-insensitive ALU driver and its benches.
package alu_li_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

   // Float32 constants handy for directed stimulus
   localparam logic [31:0] FP_1 = 32'h3f800000;
   localparam logic [31:0] FP_2 = 32'h40000000;
   localparam logic [31:0] FP_3 = 32'h40400000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } driver_state_e;

endpackage

// File: rtl/alu_li_driver_if.sv
// Bundle of the command, ALU, result and status signals around the driver.
// master: the driver side.  slave: the environment (source, ALU, consumer).
interface alu_li_driver_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
);
   logic             start;
   logic [CNT_W-1:0] num_ops;
   logic [WIDTH-1:0] cmd_a;
   logic [WIDTH-1:0] cmd_b;
   logic             cmd_op;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic             alu_op;
   logic             alu_valid;
   logic             alu_ready;
   logic [WIDTH-1:0] alu_result;
   logic             alu_res_valid;
   logic             alu_res_ready;
   logic [WIDTH-1:0] res_data;
   logic             res_valid;
   logic             res_ready;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] issued_cnt;
   logic [CNT_W-1:0] retired_cnt;
   logic             err;

   modport master (
      input  start, num_ops, cmd_a, cmd_b, cmd_op, cmd_valid,
      input  alu_ready, alu_result, alu_res_valid, res_ready,
      output cmd_ready, alu_a, alu_b, alu_op, alu_valid, alu_res_ready,
      output res_data, res_valid, busy, done, issued_cnt, retired_cnt, err
   );

   modport slave (
      output start, num_ops, cmd_a, cmd_b, cmd_op, cmd_valid,
      output alu_ready, alu_result, alu_res_valid, res_ready,
      input  cmd_ready, alu_a, alu_b, alu_op, alu_valid, alu_res_ready,
      input  res_data, res_valid, busy, done, issued_cnt, retired_cnt, err
   );
endinterface

// File: rtl/alu_li_driver_fifo.sv
// Small synchronous FIFO for ALU results. Storage is flop based, so the head
// word is a register output and a pushed word is visible the next cycle.
module li_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign empty_o = (cnt_q == '0);
   // Upstream credits keep pushes off a full FIFO; the gate is only a safety net
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rd_q];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= wr_q + 1'b1;
         if (pop_ok)  rd_q <= rd_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage write; cleared on reset so the idle head word is deterministic
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_q] <= wdata_i;
      end
   end
endmodule

// File: rtl/alu_li_driver.sv
// Initiator for the latency-insensitive ALU: issues a batch of commands under
// a credit limit and returns results in order through an internal FIFO.
module alu_li_driver
   import alu_li_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 16
) (
   input  logic            clk,
   input  logic            reset,
   alu_li_driver_if.master bus
);
   localparam int CR_W = $clog2(MAX_OUT + 1);

   driver_state_e    state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic [CR_W-1:0]  credits_q, credits_d;
   logic             err_q, err_d;
   logic             start_ok, has_credit, issue, pop, push, bad_res;
   logic             fifo_full, fifo_empty;

   // Issue path is a straight pass-through gated by state and credits
   assign has_credit    = (credits_q != '0);
   assign bus.alu_a     = bus.cmd_a;
   assign bus.alu_b     = bus.cmd_b;
   assign bus.alu_op    = bus.cmd_op;
   assign bus.alu_valid = bus.cmd_valid & (state_q == RUN) & has_credit;
   assign bus.cmd_ready = bus.alu_ready & (state_q == RUN) & has_credit;
   // Credits reserve FIFO space for every in-flight op, so results are never refused
   assign bus.alu_res_ready = reset;

   assign start_ok = (state_q == IDLE) & bus.start;
   assign issue    = bus.alu_valid & bus.alu_ready;
   assign pop      = bus.res_valid & bus.res_ready;
   // A result with nothing outstanding (or while idle) is flagged and dropped
   assign bad_res  = bus.alu_res_valid & ((state_q == IDLE) | (retired_q == issued_q));
   assign push     = bus.alu_res_valid & ~bad_res;

   assign bus.issued_cnt  = issued_q;
   assign bus.retired_cnt = retired_q;
   assign bus.err         = err_q;

   li_fifo #(.WIDTH(WIDTH), .DEPTH(MAX_OUT)) u_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (push),
      .wdata_i (bus.alu_result),
      .pop_i   (pop),
      .rdata_o (bus.res_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );
   assign bus.res_valid = ~fifo_empty;

   // Counter, credit and error next-state
   always_comb begin
      num_d     = num_q;
      issued_d  = issued_q;
      retired_d = retired_q;
      credits_d = credits_q;
      err_d     = err_q | bad_res;
      if (start_ok) begin
         num_d     = bus.num_ops;
         issued_d  = '0;
         retired_d = '0;
      end else begin
         if (issue) issued_d  = issued_q + 1'b1;
         if (push)  retired_d = retired_q + 1'b1;
      end
      case ({issue, pop})
         2'b10:   credits_d = credits_q - CR_W'(1);
         2'b01:   credits_d = credits_q + CR_W'(1);
         default: credits_d = credits_q;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_q     <= '0;
         issued_q  <= '0;
         retired_q <= '0;
         credits_q <= CR_W'(MAX_OUT);
         err_q     <= 1'b0;
      end else begin
         num_q     <= num_d;
         issued_q  <= issued_d;
         retired_q <= retired_d;
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state; RUN looks at the post-issue count so it never over-issues
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = (bus.num_ops == '0) ? DONE : RUN;
         RUN:     if (issued_d == num_q) state_d = DRAIN;
         DRAIN:   if ((retired_q == num_q) && fifo_empty) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      bus.busy = (state_q == RUN) || (state_q == DRAIN);
      bus.done = (state_q == DONE);
   end
endmodule

// File: tb/tb_alu_li_driver.sv
// Bench for alu_li_driver: behavioural ALU, command source and an in-order
// scoreboard on the result stream.
module tb_alu_li_driver;
   import alu_li_pkg::*;

   localparam int WIDTH   = 32;
   localparam int MAX_OUT = 4;
   localparam int CNT_W   = 16;
   localparam int NCMD    = 11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_li_driver_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus();

   alu_li_driver #(.WIDTH(WIDTH), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.master)
   );

   int checks = 0;
   int errors = 0;
   int iss_cnt = 0;
   int done_cnt = 0;
   int res_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] alu_q[$];

   logic [31:0] tab_a [NCMD];
   logic [31:0] tab_b [NCMD];
   logic        tab_op[NCMD];
   logic [31:0] tab_r [NCMD];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Float32 <-> small positive integer helpers for the ALU model
   function automatic int f2i(input logic [31:0] x);
      int e;
      logic [23:0] m;
      e = int'(x[30:23]) - 127;
      m = {1'b1, x[22:0]};
      return int'(m >> (23 - e));
   endfunction

   function automatic logic [31:0] i2f(input int v);
      int p;
      logic [31:0] sh;
      p = 0;
      for (int i = 0; i < 24; i++) if (v[i]) p = i;
      sh = 32'(v) << (23 - p);
      return {1'b0, 8'(127 + p), sh[22:0]};
   endfunction

   function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b, input logic op);
      if (op == OP_MUL) return i2f(f2i(a) * f2i(b));
      return i2f(f2i(a) + f2i(b));
   endfunction

   // ALU model: one cycle of latency, in order, always ready, shares reset
   logic        mdl_vld;
   logic [31:0] mdl_data;
   logic        spur = 1'b0;
   logic [31:0] spur_data = '0;
   assign bus.alu_ready     = 1'b1;
   assign bus.alu_res_valid = mdl_vld | spur;
   assign bus.alu_result    = spur ? spur_data : mdl_data;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_q.delete();
         mdl_vld  <= 1'b0;
         mdl_data <= '0;
      end else begin
         mdl_vld <= 1'b0;
         if (alu_q.size() > 0) begin
            mdl_vld  <= 1'b1;
            mdl_data <= alu_q.pop_front();
         end
         if (bus.alu_valid && bus.alu_ready) begin
            iss_cnt++;
            alu_q.push_back(fp_calc(bus.alu_a, bus.alu_b, bus.alu_op));
         end
      end
   end

   // Result monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) done_cnt++;
         if (bus.res_valid && bus.res_ready) begin
            res_cnt++;
            if (exp_q.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
            else chk("result", bus.res_data, exp_q.pop_front());
         end
      end
   end

   task automatic send_range(input int lo, input int hi);
      bit hs;
      for (int k = lo; k <= hi; k++) begin
         bus.cmd_a     = tab_a[k];
         bus.cmd_b     = tab_b[k];
         bus.cmd_op    = tab_op[k];
         bus.cmd_valid = 1'b1;
         hs = 1'b0;
         for (int c = 0; c < 200 && !hs; c++) begin
            @(negedge clk);
            hs = bus.cmd_ready;
            @(posedge clk); #1;
         end
         if (!hs) chk("cmd_timeout", 32'd0, 32'd1);
         else exp_q.push_back(tab_r[k]);
      end
      bus.cmd_valid = 1'b0;
   endtask

   task automatic start_batch(input int n);
      bus.num_ops = CNT_W'(n);
      bus.start   = 1'b1;
      @(posedge clk); #1;
      bus.start   = 1'b0;
   endtask

   task automatic wait_done(input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cyc && !seen; c++) begin
         @(negedge clk);
         seen = bus.done;
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
      else begin
         chk("drained_at_done", 32'(exp_q.size()), 32'd0);
         @(negedge clk);
         chk("done_one_cycle", 32'(bus.done), 32'd0);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int base, dbase, rbase;
      tab_a = '{FP_1, FP_1, FP_3, FP_2, FP_3, FP_1, FP_3, FP_2, FP_2, FP_1, FP_1};
      tab_b = '{FP_2, FP_2, FP_2, FP_2, FP_3, FP_1, FP_3, FP_3, FP_2, FP_3, FP_3};
      tab_op = '{OP_ADD, OP_MUL, OP_MUL, OP_ADD, OP_ADD, OP_ADD, OP_MUL, OP_ADD, OP_MUL, OP_MUL, OP_ADD};
      tab_r = '{32'h40400000, 32'h40000000, 32'h40c00000, 32'h40800000, 32'h40c00000,
                32'h40000000, 32'h41100000, 32'h40a00000, 32'h40800000, 32'h40400000,
                32'h40800000};
      bus.start = 1'b0; bus.num_ops = '0; bus.cmd_a = '0; bus.cmd_b = '0;
      bus.cmd_op = 1'b0; bus.cmd_valid = 1'b0; bus.res_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_outs", 32'({bus.alu_valid, bus.cmd_ready, bus.res_valid, bus.busy, bus.done, bus.err}), 32'd0);
      chk("rst_cnts", 32'({bus.issued_cnt, bus.retired_cnt}), 32'd0);
      rst_n = 1'b1;
      #1 chk("alu_res_ready", 32'(bus.alu_res_ready), 32'd1);
      @(posedge clk); #1;

      // Single add
      bus.res_ready = 1'b1;
      dbase = done_cnt;
      start_batch(1);
      send_range(0, 0);
      wait_done(100);
      chk("single_issued", 32'(bus.issued_cnt), 32'd1);
      chk("single_retired", 32'(bus.retired_cnt), 32'd1);
      chk("single_done_cnt", 32'(done_cnt - dbase), 32'd1);

      // Mixed batch of 3
      dbase = done_cnt;
      start_batch(3);
      send_range(0, 2);
      wait_done(100);
      chk("mixed_issued", 32'(bus.issued_cnt), 32'd3);
      chk("mixed_retired", 32'(bus.retired_cnt), 32'd3);
      chk("mixed_done_cnt", 32'(done_cnt - dbase), 32'd1);

      // Backpressure: credits cap outstanding work at MAX_OUT
      bus.res_ready = 1'b0;
      base  = iss_cnt;
      rbase = res_cnt;
      start_batch(8);
      fork
         send_range(3, 10);
      join_none
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("bp_issues", 32'(iss_cnt - base), 32'(MAX_OUT));
      chk("bp_alu_valid", 32'(bus.alu_valid), 32'd0);
      chk("bp_res_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_busy", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      wait_done(400);
      wait fork;
      chk("bp_total_issues", 32'(iss_cnt - base), 32'd8);
      chk("bp_results", 32'(res_cnt - rbase), 32'd8);
      chk("bp_retired", 32'(bus.retired_cnt), 32'd8);

      // Empty batch
      base = iss_cnt;
      start_batch(0);
      @(negedge clk);
      chk("zero_done", 32'(bus.done), 32'd1);
      chk("zero_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("zero_done_drop", 32'(bus.done), 32'd0);
      chk("zero_issues", 32'(iss_cnt - base), 32'd0);
      @(posedge clk); #1;

      // Spurious ALU result while idle
      spur_data = FP_3;
      spur = 1'b1;
      @(posedge clk); #1;
      spur = 1'b0;
      @(negedge clk);
      chk("spur_err", 32'(bus.err), 32'd1);
      chk("spur_fifo", 32'(bus.res_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("spur_sticky", 32'(bus.err), 32'd1);
      rst_n = 1'b0;
      #1 chk("spur_rst_clear", 32'(bus.err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset in the middle of a batch with two results outstanding
      bus.res_ready = 1'b0;
      start_batch(4);
      send_range(0, 1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      bus.cmd_a = FP_1; bus.cmd_b = FP_1; bus.cmd_op = OP_ADD;
      bus.cmd_valid = 1'b1;
      #1 chk("pre_rst", 32'({bus.busy, bus.alu_valid, bus.res_valid}), 32'd7);
      rst_n = 1'b0;
      #1 chk("mid_rst", 32'({bus.busy, bus.alu_valid, bus.res_valid}), 32'd0);
      bus.cmd_valid = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b1;
      dbase = done_cnt;
      start_batch(1);
      send_range(3, 3);
      wait_done(100);
      chk("post_rst_issued", 32'(bus.issued_cnt), 32'd1);
      chk("post_rst_retired", 32'(bus.retired_cnt), 32'd1);
      chk("post_rst_done", 32'(done_cnt - dbase), 32'd1);
      chk("post_rst_err", 32'(bus.err), 32'd0);

      chk("total_results", 32'(res_cnt), 32'd13);
      chk("sb_leftover", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
